// File: rtl/hs_fetch_ctrl.sv
// hs_fetch_ctrl: instruction-fetch request generator feeding the fetch-queue FIFO.
//
// Issues sequential, word-aligned fetch requests on a valid/ready memory port,
// tags each in-order response with the PC it was fetched from and pushes
// {pc, insn} into the downstream FIFO. Requests are throttled by a credit
// counter (one credit per free FIFO slot) so a push is never refused, and by
// an outstanding-request limit. A flush redirects fetch to a new PC and
// discards every response still in flight at that moment.
//
// Ports:
//   clk_core, rst_core_n      core clock, asynchronous active-low reset
//   flush, redirect_pc        redirect strobe and new fetch PC (bits[1:0] ignored)
//   req_valid_o, req_ready_i  fetch request handshake
//   req_addr_o                fetch address (word aligned)
//   rsp_valid_i, rsp_data_i   in-order response beat, never back-pressured
//   ready_i                   FIFO ready (guaranteed high by the credit scheme)
//   valid_o, out              FIFO push strobe and {pc, insn} payload
//   pop_i                     FIFO output handshake, returns one credit

module hs_fetch_ctrl #(
    parameter int              XLEN            = 32,
    parameter int              ILEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int              CREDITS         = 3,
    parameter int              MAX_OUTSTANDING = 4
) (
    input  logic                 clk_core,
    input  logic                 rst_core_n,
    input  logic                 flush,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [XLEN-1:0]      req_addr_o,
    input  logic                 rsp_valid_i,
    input  logic [ILEN-1:0]      rsp_data_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [XLEN+ILEN-1:0] out,
    input  logic                 pop_i
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CW-1:0]   CR_FULL   = CW'(CREDITS);
    localparam logic [CW+1:0]   CR_FULL_W = (CW+2)'(CREDITS);
    localparam logic [OW-1:0]   OUT_MAX   = OW'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [XLEN-1:0]        addr_r;
    logic [XLEN-1:0]        rsp_pc_r;
    logic [CW-1:0]          credits_r;
    logic [OW-1:0]          outstanding_r;
    logic [OW-1:0]          discard_r;
    logic                   valid_r;
    logic [XLEN+ILEN-1:0]   out_r;

    logic                   req_valid_s;
    logic                   fire_s;
    logic                   drop_s;
    logic                   accept_s;
    logic [XLEN-1:0]        redirect_aligned_s;
    logic [OW-1:0]          out_inc_s;
    logic [OW-1:0]          outstanding_nx_s;
    logic [CW+1:0]          cr_sum_s;
    logic [CW+1:0]          cr_net_s;
    logic [CW-1:0]          credits_nx_s;
    logic [OW-1:0]          discard_nx_s;

    // BOOT lasts exactly one cycle after reset release; RUN is absorbing.
    always_comb begin
        state_nx_s = ST_BOOT;
        case (state_r)
            ST_BOOT: state_nx_s = ST_RUN;
            ST_RUN:  state_nx_s = ST_RUN;
            default: state_nx_s = ST_BOOT;
        endcase
    end

    // Handshake decode: issue permission comes only from registered state
    // (never from req_ready_i); flush suppresses issue for its own cycle.
    always_comb begin
        req_valid_s        = 1'b0;
        redirect_aligned_s = {redirect_pc[XLEN-1:2], 2'b00};
        if ((state_r == ST_RUN) && !flush &&
            (credits_r != {CW{1'b0}}) && (outstanding_r < OUT_MAX)) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        fire_s   = req_valid_s & req_ready_i;
        drop_s   = rsp_valid_i & (discard_r != {OW{1'b0}});
        accept_s = rsp_valid_i & (discard_r == {OW{1'b0}}) & !flush;
    end

    // In-flight request count after this cycle's fire and response.
    always_comb begin
        out_inc_s = outstanding_r + {{(OW-1){1'b0}}, fire_s};
        if (rsp_valid_i && (out_inc_s != {OW{1'b0}})) begin
            outstanding_nx_s = out_inc_s - {{(OW-1){1'b0}}, 1'b1};
        end else begin
            outstanding_nx_s = out_inc_s;
        end
    end

    // Credit update: pops and discarded responses return credits, a fire
    // consumes one; the result saturates at the FIFO capacity.
    always_comb begin
        cr_sum_s = {2'b00, credits_r}
                 + {{(CW+1){1'b0}}, pop_i}
                 + {{(CW+1){1'b0}}, drop_s};
        if (fire_s && (cr_sum_s != {(CW+2){1'b0}})) begin
            cr_net_s = cr_sum_s - {{(CW+1){1'b0}}, 1'b1};
        end else begin
            cr_net_s = cr_sum_s;
        end
        if (cr_net_s > CR_FULL_W) begin
            credits_nx_s = CR_FULL;
        end else begin
            credits_nx_s = cr_net_s[CW-1:0];
        end
    end

    // A flush marks everything still in flight (including a same-cycle
    // fire) as stale; otherwise each dropped response retires one stale slot.
    always_comb begin
        discard_nx_s = discard_r;
        if (flush) begin
            discard_nx_s = outstanding_nx_s;
        end else if (drop_s) begin
            discard_nx_s = discard_r - {{(OW-1){1'b0}}, 1'b1};
        end else begin
            discard_nx_s = discard_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Fetch address and response-tag PC; both restart at the redirect target.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            addr_r   <= RESET_PC;
            rsp_pc_r <= RESET_PC;
        end else if (flush) begin
            addr_r   <= redirect_aligned_s;
            rsp_pc_r <= redirect_aligned_s;
        end else begin
            if (fire_s) begin
                addr_r <= addr_r + PC_STEP;
            end else begin
                addr_r <= addr_r;
            end
            if (accept_s) begin
                rsp_pc_r <= rsp_pc_r + PC_STEP;
            end else begin
                rsp_pc_r <= rsp_pc_r;
            end
        end
    end

    // Credit, outstanding and discard counters.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            credits_r     <= CR_FULL;
            outstanding_r <= {OW{1'b0}};
            discard_r     <= {OW{1'b0}};
        end else begin
            if (flush) begin
                credits_r <= CR_FULL;
            end else begin
                credits_r <= credits_nx_s;
            end
            outstanding_r <= outstanding_nx_s;
            discard_r     <= discard_nx_s;
        end
    end

    // Registered FIFO push: one-cycle pulse per accepted response.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            valid_r <= 1'b0;
            out_r   <= {(XLEN+ILEN){1'b0}};
        end else begin
            valid_r <= accept_s;
            if (accept_s) begin
                out_r <= {rsp_pc_r, rsp_data_i};
            end else begin
                out_r <= out_r;
            end
        end
    end

    assign req_valid_o = req_valid_s;
    assign req_addr_o  = addr_r;
    assign valid_o     = valid_r;
    assign out         = out_r;

    hs_fetch_ctrl_chk #(
        .OW (OW)
    ) u_chk (
        .clk         (clk_core),
        .rst_n       (rst_core_n),
        .push_valid  (valid_r),
        .push_ready  (ready_i),
        .rsp_valid   (rsp_valid_i),
        .outstanding (outstanding_r)
    );

endmodule

// hs_fetch_ctrl_chk: protocol checks for hs_fetch_ctrl.
// Ports: clk/rst_n, push handshake, response strobe, in-flight count.
module hs_fetch_ctrl_chk #(
    parameter int OW = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push_valid,
    input logic          push_ready,
    input logic          rsp_valid,
    input logic [OW-1:0] outstanding
);

    // The credit scheme must keep the FIFO able to take every push.
    a_push_ready: assert property (@(posedge clk) disable iff (!rst_n)
        push_valid |-> push_ready);

    // Memory may only answer requests that were actually issued.
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (outstanding != {OW{1'b0}}));

endmodule
